cache_refill_control: RTL and testbench
=======================================

# cache_refill_control

Miss-handling controller that sits between the split instruction/data caches and a shared 16-bit block RAM. When either cache reports a miss it stalls that cache, writes back the displaced line when enabled and needed, then refills the line with two halfword RAM reads and one word cache write. Instruction misses take priority over data misses.

## Interface
- No parameters. Line size is 4 bytes, 256 lines, tag is addr[31:10], index is addr[9:2].
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `instruction_cache_miss` in 4: per-byte miss flags of the instruction access. Bit i refers to byte `instruction_mem_addr+i`.
- `instruction_cache_tag` in 22: tag stored in the instruction line that misses (unused).
- `instruction_mem_addr` in 32: instruction fetch byte address.
- `data_cache_miss` in 4: per-byte miss flags of the data access.
- `data_cache_tag` in 22: tag currently held in the missing data line.
- `data_cache_valid` in 4: per-byte flag; 1 means the missing line holds valid data that must be written back.
- `data_mem_addr` in 32: data access byte address.
- `data_mem_rd_data` in 32: data cache word read at `cache_addr` while stalled.
- `data_cache_stall` out 1: data side is blocked.
- `instruction_cache_stall` out 1: instruction side is blocked.
- `cache_wr_en` out CacheWrControl: fill write strobe.
- `cache_rd_type` out CacheRdControl: write-back read strobe.
- `cache_addr` out 32: line base address for fill or write-back.
- `cache_wr_data` out 32: fill word.
- `ram_rd_data_in` in 16: RAM read data, arriving 1 cycle after its address.
- `ram_wr_data_out` out 16: RAM write data.
- `ram_wr_en` out 1: RAM write enable.
- `ram_wr_addr_out` out 32: RAM halfword write address.
- `ram_rd_addr_out` out 32: RAM halfword read address.

## Operation
- **Target line.**
  - The serviced side is the instruction cache if any bit of `instruction_cache_miss` is set, else the data cache.
  - i is the lowest set miss bit of the serviced side.
  - base = (addr+i) & ~3.
  - The RAM halfword address of a byte address is byte>>1.
- **States:** IDLE, WB_LO, WB_HI, RD_LO, RD_HI, RD_WAIT, FILL.
- **IDLE.**
  - On an instruction miss, latch base and side=INST, go to RD_LO.
  - On a data miss with `data_cache_valid[i]`=1, latch the write-back address {data_cache_tag, base[9:2], 2'b00} and go to WB_LO.
  - On a data miss without it, go to RD_LO.
- **WB_LO.**
  - `cache_addr`=base, `cache_rd_type`=CACHE_W_RD.
  - `ram_wr_en`=1, `ram_wr_addr_out`=wb>>1, `ram_wr_data_out`=`data_mem_rd_data`[15:0].
- **WB_HI.** Same as WB_LO, with address +1 and data [31:16]. Next state is RD_LO.
- **RD_LO.** `ram_rd_addr_out`=base>>1.
- **RD_HI.** `ram_rd_addr_out`=(base>>1)+1; capture `ram_rd_data_in` as low half.
- **RD_WAIT.** Capture the high half.
- **FILL.**
  - `cache_addr`=base, `cache_wr_data`={hi,lo}, `cache_wr_en`=CACHE_W_WR for exactly 1 cycle.
  - Then IDLE. Remaining misses, such as an access straddling two lines, are re-evaluated there.
- **Idle values.** Outside the states above: `cache_wr_en`=CACHE_NO_WR, `cache_rd_type`=CACHE_NO_RD, `ram_wr_en`=0, and the address/data outputs are 0.
- **Stalls.**
  - `instruction_cache_stall` = (busy with side=INST) | (IDLE & |`instruction_cache_miss`).
  - `data_cache_stall` = |`data_cache_miss` | (busy with side=DATA).
  - An instruction miss arriving during a data service waits until IDLE; the data service is never preempted.

## Timing
- **Reset.** Async reset forces IDLE. All outputs read 0/NO while `reset_n` is low, stalls included.
- **Reset mid-service.** The service is aborted with no cache write; a RAM write already issued stands.
- **Latency.**
  - Refill: FILL occurs in the 4th cycle after the IDLE cycle that detects the miss.
  - With write-back: 6th cycle.
  - The stall drops the cycle after FILL once the cache reports no miss.
- **Simultaneous misses.** Instruction is serviced first.

## Configuration
- Macro `CACHE_CTRL_WRITEBACK_EN`.
  - Defined: write-back behaves as above.
  - Undefined: WB states are removed, `data_cache_valid` and `data_cache_tag` are ignored, and displaced lines are discarded.

## Structure
- `package_project_typedefs` holds:
  - CacheWrControl {CACHE_NO_WR=0, CACHE_B_WR, CACHE_H_WR, CACHE_W_WR}, 2 bits.
  - CacheRdControl {CACHE_NO_RD=0, CACHE_B_RD, CACHE_H_RD, CACHE_W_RD}, 2 bits.
  - The line geometry constants.
- One FSM module. No sub-modules are needed; the RAM and the caches are external.

## Test plan
- **Instruction refill.** RAM words at 0 = AABBCCDD. Instruction miss at address 0 → reads of halfwords 0 and 1, FILL with `cache_addr`=0 and `cache_wr_data`=AABBCCDD, then `instruction_cache_stall` drops.
- **Straddling data access.** Word write of AA998811 at 1601, no valid data, instruction miss also pending → instruction fill first, then data fills at bases 1600 and 1604; `ram_wr_en` never asserts.
- **Write-back.** Instruction address 3072 (RAM 11223344) plus a byte write at 2627, index 144 (same as 1600) → instruction fill 11223344 first, then write-back of halfwords 800/801 = 1100/9988 (line word 99881100), then fill of 2624.
- **Priority.** Both misses in the same cycle → `cache_wr_en` first asserts with `cache_addr` = instruction base; `data_cache_stall` stays 1 throughout.
- **Reset mid-service.** Pulse `reset_n` low during RD_HI → state IDLE, no CACHE_W_WR, all outputs 0 while low, and the service restarts after release.
- **Macro undefined.** The write-back scenario produces no RAM writes and the fill occurs in the 4th cycle.

Source files
------------

// File: rtl/cache_refill_control_pkg.sv
// Shared types for the cache refill controller: cache strobe encodings,
// line geometry, FSM state/side encodings and small address helpers.
package package_project_typedefs;

  typedef enum logic [1:0] {
    CACHE_NO_WR = 2'd0,
    CACHE_B_WR  = 2'd1,
    CACHE_H_WR  = 2'd2,
    CACHE_W_WR  = 2'd3
  } CacheWrControl;

  typedef enum logic [1:0] {
    CACHE_NO_RD = 2'd0,
    CACHE_B_RD  = 2'd1,
    CACHE_H_RD  = 2'd2,
    CACHE_W_RD  = 2'd3
  } CacheRdControl;

  // 4-byte lines, 256 of them: tag = addr[31:10], index = addr[9:2].
  localparam int OFFSET_W = 2;
  localparam int INDEX_W  = 8;
  localparam int TAG_W    = 32 - INDEX_W - OFFSET_W;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WB_LO   = 3'd1,
    ST_WB_HI   = 3'd2,
    ST_RD_LO   = 3'd3,
    ST_RD_HI   = 3'd4,
    ST_RD_WAIT = 3'd5,
    ST_FILL    = 3'd6
  } refill_state_t;

  typedef enum logic {
    SIDE_INST = 1'b0,
    SIDE_DATA = 1'b1
  } refill_side_t;

  // Position of the lowest set per-byte miss flag (3 when only bit 3 or none is set).
  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // Line base address of the byte at addr+off.
  function automatic logic [31:0] line_base(input logic [31:0] addr, input logic [1:0] off);
    return (addr + {30'd0, off}) & ~((32'd1 << OFFSET_W) - 32'd1);
  endfunction

endpackage

// File: rtl/cache_refill_control_if.sv
// Bus bundle between the refill controller (master) and the caches/RAM (slave).
interface cache_refill_control_if;
  import package_project_typedefs::*;

  // Handshake: a non-zero *_cache_miss is a request that the cache holds
  // until the line is present; *_cache_stall is the inverse of ready and
  // stays high until the cycle after the fill that clears the miss. RAM read
  // data is valid one cycle after its address; a RAM write and a cache fill
  // each take effect on the rising edge that ends the cycle they are driven in.
  logic [3:0]       instruction_cache_miss;
  logic [TAG_W-1:0] instruction_cache_tag;
  logic [31:0]      instruction_mem_addr;
  logic [3:0]       data_cache_miss;
  logic [TAG_W-1:0] data_cache_tag;
  logic [3:0]       data_cache_valid;
  logic [31:0]      data_mem_addr;
  logic [31:0]      data_mem_rd_data;
  logic             data_cache_stall;
  logic             instruction_cache_stall;
  CacheWrControl    cache_wr_en;
  CacheRdControl    cache_rd_type;
  logic [31:0]      cache_addr;
  logic [31:0]      cache_wr_data;
  logic [15:0]      ram_rd_data_in;
  logic [15:0]      ram_wr_data_out;
  logic             ram_wr_en;
  logic [31:0]      ram_wr_addr_out;
  logic [31:0]      ram_rd_addr_out;

  modport master (
    input  instruction_cache_miss, instruction_cache_tag, instruction_mem_addr,
    input  data_cache_miss, data_cache_tag, data_cache_valid, data_mem_addr,
    input  data_mem_rd_data, ram_rd_data_in,
    output data_cache_stall, instruction_cache_stall, cache_wr_en, cache_rd_type,
    output cache_addr, cache_wr_data, ram_wr_data_out, ram_wr_en,
    output ram_wr_addr_out, ram_rd_addr_out
  );

  modport slave (
    output instruction_cache_miss, instruction_cache_tag, instruction_mem_addr,
    output data_cache_miss, data_cache_tag, data_cache_valid, data_mem_addr,
    output data_mem_rd_data, ram_rd_data_in,
    input  data_cache_stall, instruction_cache_stall, cache_wr_en, cache_rd_type,
    input  cache_addr, cache_wr_data, ram_wr_data_out, ram_wr_en,
    input  ram_wr_addr_out, ram_rd_addr_out
  );

endinterface

// File: rtl/cache_refill_control.sv
// Miss-handling FSM between split I/D caches and a 16-bit block RAM.
// Instruction misses win over data misses; a data service is never preempted.
// Build option: CACHE_CTRL_WRITEBACK_EN compiles in write-back of displaced
// valid data lines; without it those lines are simply overwritten.
module cache_refill_control
  import package_project_typedefs::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  cache_refill_control_if.master bus,
  output refill_state_t          fsm_state
);

  refill_state_t state_q, state_d;
  refill_side_t  side_q, side_d;
  logic [31:0]   base_q, base_d;
  logic [15:0]   lo_q, lo_d;
  logic [15:0]   hi_q, hi_d;
`ifdef CACHE_CTRL_WRITEBACK_EN
  // Halfword RAM address of the displaced line.
  logic [31:0]   wb_q, wb_d;
`endif

  logic        inst_req;
  logic        data_req;
  logic        busy;
  logic [1:0]  inst_i;
  logic [1:0]  data_i;
  logic [31:0] inst_base;
  logic [31:0] data_base;
  logic        unused_inputs;

  assign inst_req  = |bus.instruction_cache_miss;
  assign data_req  = |bus.data_cache_miss;
  assign inst_i    = lowest_set(bus.instruction_cache_miss);
  assign data_i    = lowest_set(bus.data_cache_miss);
  assign inst_base = line_base(bus.instruction_mem_addr, inst_i);
  assign data_base = line_base(bus.data_mem_addr, data_i);
  assign busy      = (state_q != ST_IDLE);
  assign fsm_state = state_q;

`ifdef CACHE_CTRL_WRITEBACK_EN
  assign unused_inputs = ^bus.instruction_cache_tag;
`else
  assign unused_inputs = ^{bus.instruction_cache_tag, bus.data_cache_tag,
                           bus.data_cache_valid, bus.data_mem_rd_data};
`endif

  // Stalls are forced low while reset is held, including the input-driven terms.
  assign bus.instruction_cache_stall = reset_n &
    ((busy & (side_q == SIDE_INST)) | (!busy & inst_req));
  assign bus.data_cache_stall = reset_n &
    (data_req | (busy & (side_q == SIDE_DATA)));

  // State and line registers; an asynchronous reset abandons any service in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      side_q  <= SIDE_INST;
      base_q  <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
`ifdef CACHE_CTRL_WRITEBACK_EN
      wb_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      side_q  <= side_d;
      base_q  <= base_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
`ifdef CACHE_CTRL_WRITEBACK_EN
      wb_q    <= wb_d;
`endif
    end
  end

  // Next-state logic and per-state cache/RAM strobes; everything idles at zero.
  always_comb begin
    state_d = state_q;
    side_d  = side_q;
    base_d  = base_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
`ifdef CACHE_CTRL_WRITEBACK_EN
    wb_d    = wb_q;
`endif
    bus.cache_wr_en     = CACHE_NO_WR;
    bus.cache_rd_type   = CACHE_NO_RD;
    bus.cache_addr      = '0;
    bus.cache_wr_data   = '0;
    bus.ram_wr_en       = 1'b0;
    bus.ram_wr_data_out = '0;
    bus.ram_wr_addr_out = '0;
    bus.ram_rd_addr_out = '0;

    case (state_q)
      ST_IDLE: begin
        if (inst_req) begin
          side_d  = SIDE_INST;
          base_d  = inst_base;
          state_d = ST_RD_LO;
        end else if (data_req) begin
          side_d  = SIDE_DATA;
          base_d  = data_base;
          state_d = ST_RD_LO;
`ifdef CACHE_CTRL_WRITEBACK_EN
          if (bus.data_cache_valid[data_i]) begin
            wb_d    = {1'b0, bus.data_cache_tag, data_base[OFFSET_W +: INDEX_W], 1'b0};
            state_d = ST_WB_LO;
          end
`endif
        end
      end
`ifdef CACHE_CTRL_WRITEBACK_EN
      ST_WB_LO: begin
        bus.cache_addr      = base_q;
        bus.cache_rd_type   = CACHE_W_RD;
        bus.ram_wr_en       = 1'b1;
        bus.ram_wr_addr_out = wb_q;
        bus.ram_wr_data_out = bus.data_mem_rd_data[15:0];
        state_d             = ST_WB_HI;
      end
      ST_WB_HI: begin
        bus.cache_addr      = base_q;
        bus.cache_rd_type   = CACHE_W_RD;
        bus.ram_wr_en       = 1'b1;
        bus.ram_wr_addr_out = wb_q + 32'd1;
        bus.ram_wr_data_out = bus.data_mem_rd_data[31:16];
        state_d             = ST_RD_LO;
      end
`endif
      ST_RD_LO: begin
        bus.ram_rd_addr_out = base_q >> 1;
        state_d             = ST_RD_HI;
      end
      ST_RD_HI: begin
        bus.ram_rd_addr_out = (base_q >> 1) + 32'd1;
        lo_d                = bus.ram_rd_data_in;
        state_d             = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        hi_d    = bus.ram_rd_data_in;
        state_d = ST_FILL;
      end
      ST_FILL: begin
        bus.cache_addr    = base_q;
        bus.cache_wr_data = {hi_q, lo_q};
        bus.cache_wr_en   = CACHE_W_WR;
        state_d           = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_refill_control.sv
// Bench for cache_refill_control: behavioural I/D caches and a 16-bit RAM
// around the DUT, directed scenarios, and a scoreboard of expected fills and
// RAM writes consumed by a monitor. Honours CACHE_CTRL_WRITEBACK_EN.
`timescale 1ns/1ps
module tb_cache_refill_control;
  import package_project_typedefs::*;

`ifdef CACHE_CTRL_WRITEBACK_EN
  localparam int WB_EXTRA   = 2;
  localparam int EXP_RAM_WR = 2;
`else
  localparam int WB_EXTRA   = 0;
  localparam int EXP_RAM_WR = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  refill_state_t fsm_state;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cache_refill_control_if bus();

  cache_refill_control dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // ---------------- stimulus controls ----------------
  logic        i_act       = 1'b0;
  logic [31:0] i_addr      = '0;
  logic        d_act       = 1'b0;
  logic [31:0] d_addr      = '0;
  int          d_size      = 0;
  logic [31:0] d_wdata     = '0;
  logic        do_store    = 1'b0;
  logic        load_en     = 1'b0;
  logic [11:0] load_addr   = '0;
  logic [15:0] load_data   = '0;
  logic        cache_clear = 1'b0;

  // ---------------- cache and RAM models ----------------
  logic [15:0] ram_mem [0:4095];
  logic        ivld [0:255];
  logic [21:0] itag [0:255];
  logic        dvld [0:255];
  logic        ddirty [0:255];
  logic [21:0] dtag [0:255];
  logic [31:0] ddata [0:255];
  logic [31:0] ia, da;
  logic        found;

  assign bus.instruction_mem_addr = i_addr;
  assign bus.data_mem_addr        = d_addr;
  assign bus.data_mem_rd_data     = ddata[bus.cache_addr[9:2]];

  always_comb begin
    ia = '0;
    da = '0;
    found = 1'b0;
    bus.instruction_cache_miss = '0;
    bus.instruction_cache_tag  = itag[i_addr[9:2]];
    bus.data_cache_miss  = '0;
    bus.data_cache_valid = '0;
    bus.data_cache_tag   = '0;
    for (int b = 0; b < 4; b++) begin
      ia = i_addr + 32'(b);
      if (i_act && !(ivld[ia[9:2]] && itag[ia[9:2]] == ia[31:10]))
        bus.instruction_cache_miss[b] = 1'b1;
      da = d_addr + 32'(b);
      if (d_act && b < d_size && !(dvld[da[9:2]] && dtag[da[9:2]] == da[31:10])) begin
        bus.data_cache_miss[b]  = 1'b1;
        bus.data_cache_valid[b] = dvld[da[9:2]] & ddirty[da[9:2]];
        if (!found) begin
          bus.data_cache_tag = dtag[da[9:2]];
          found = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (load_en) ram_mem[load_addr] <= load_data;
    if (bus.ram_wr_en) ram_mem[bus.ram_wr_addr_out[11:0]] <= bus.ram_wr_data_out;
    bus.ram_rd_data_in <= ram_mem[bus.ram_rd_addr_out[11:0]];
    if (cache_clear) begin
      for (int k = 0; k < 256; k++) begin
        ivld[k]   <= 1'b0;
        dvld[k]   <= 1'b0;
        ddirty[k] <= 1'b0;
        itag[k]   <= '0;
        dtag[k]   <= '0;
        ddata[k]  <= '0;
      end
    end else if (reset_n && bus.cache_wr_en == CACHE_W_WR) begin
      if (bus.instruction_cache_stall) begin
        ivld[bus.cache_addr[9:2]] <= 1'b1;
        itag[bus.cache_addr[9:2]] <= bus.cache_addr[31:10];
      end else begin
        dvld[bus.cache_addr[9:2]]   <= 1'b1;
        ddirty[bus.cache_addr[9:2]] <= 1'b0;
        dtag[bus.cache_addr[9:2]]   <= bus.cache_addr[31:10];
        ddata[bus.cache_addr[9:2]]  <= bus.cache_wr_data;
      end
    end
    if (do_store) begin
      for (int b = 0; b < 4; b++) begin
        if (b < d_size) begin
          ddata[idx_of(d_addr + 32'(b))][{off_of(d_addr + 32'(b)), 3'b000} +: 8] <= d_wdata[b*8 +: 8];
          ddirty[idx_of(d_addr + 32'(b))] <= 1'b1;
        end
      end
    end
  end

  function automatic logic [7:0] idx_of(input logic [31:0] a);
    return a[9:2];
  endfunction

  function automatic logic [1:0] off_of(input logic [31:0] a);
    return a[1:0];
  endfunction

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];      // {cache_addr, cache_wr_data}
  logic [47:0] ram_exp_q[$];  // {ram_wr_addr_out, ram_wr_data_out}
  int errors     = 0;
  int checks     = 0;
  int fill_count = 0;
  int ram_writes = 0;
  int fill_at [0:31];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    logic [63:0] e;
    logic [47:0] r;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (bus.cache_wr_en != CACHE_NO_WR) begin
          if (fill_count < 32) fill_at[fill_count] = cyc;
          fill_count++;
          if (exp_q.size() == 0) begin
            check("fill_unexpected", {bus.cache_wr_en, bus.cache_addr, bus.cache_wr_data}, '0);
          end else begin
            e = exp_q.pop_front();
            check("fill", {bus.cache_wr_en, bus.cache_addr, bus.cache_wr_data}, {CACHE_W_WR, e});
          end
        end
        if (bus.ram_wr_en) begin
          ram_writes++;
          if (ram_exp_q.size() == 0) begin
            check("ram_wr_unexpected", {bus.ram_wr_addr_out, bus.ram_wr_data_out}, '0);
          end else begin
            r = ram_exp_q.pop_front();
            check("ram_wr", {bus.ram_wr_addr_out, bus.ram_wr_data_out}, r);
          end
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_word(input logic [31:0] byte_addr, input logic [31:0] w);
    load_en = 1'b1; load_addr = byte_addr[12:1]; load_data = w[15:0];
    @(negedge clk);
    load_addr = byte_addr[12:1] + 12'd1; load_data = w[31:16];
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Wait (bounded) until neither side is stalled; count data stalls dropping early.
  task automatic wait_done(input logic de, output int done_cyc);
    int gap;
    gap = 0;
    done_cyc = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (de && !bus.data_cache_stall && bus.instruction_cache_stall) gap++;
      if (!bus.instruction_cache_stall && !bus.data_cache_stall) begin
        done_cyc = cyc;
        break;
      end
    end
    if (done_cyc < 0) check("access_timeout", 96'd0, 96'd1);
    if (de) check("dstall_held", 96'(gap), 96'd0);
  endtask

  task automatic run_access(input logic ie, input logic [31:0] ia_in, input logic de,
                            input logic [31:0] da_in, input int dsz, input logic [31:0] dwd,
                            output int start_cyc, output int done_cyc);
    @(negedge clk);
    i_act = ie; i_addr = ia_in;
    d_act = de; d_addr = da_in; d_size = dsz; d_wdata = dwd;
    start_cyc = cyc;
    wait_done(de, done_cyc);
    if (de) begin
      do_store = 1'b1;
      @(negedge clk);
      do_store = 1'b0;
    end
    i_act = 1'b0;
    d_act = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctrl"}, {bus.instruction_cache_stall, bus.data_cache_stall, bus.cache_wr_en,
                           bus.cache_rd_type, bus.ram_wr_en}, '0);
    check({tag, "_cache"}, {bus.cache_addr, bus.cache_wr_data}, '0);
    check({tag, "_ram"}, {bus.ram_rd_addr_out, bus.ram_wr_addr_out, bus.ram_wr_data_out}, '0);
    check({tag, "_state"}, fsm_state, ST_IDLE);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, m, done, fb;
    for (int k = 0; k < 32; k++) fill_at[k] = 0;
    fork
      monitor();
    join_none

    // Reset with cache clear and RAM preload.
    @(negedge clk);
    cache_clear = 1'b1;
    load_word(32'd0,    32'hAABBCCDD);
    load_word(32'h100,  32'hCAFEF00D);
    load_word(32'd1600, 32'h12345600);
    load_word(32'd1604, 32'h55667700);
    load_word(32'd3072, 32'h11223344);
    load_word(32'd2624, 32'h0BADBEEF);
    load_word(32'h200,  32'h0F1E2D3C);
    cache_clear = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Instruction refill of line 0.
    exp_q.push_back({32'd0, 32'hAABBCCDD});
    fb = fill_count;
    run_access(1'b1, 32'd0, 1'b0, 32'd0, 0, 32'd0, n, done);
    check("t1_fill_cycle", 96'(fill_at[fb]), 96'(n + 4));
    check("t1_stall_drop", 96'(done), 96'(n + 5));

    // Straddling word store at 1601 with an instruction miss in the same cycle.
    exp_q.push_back({32'h100,  32'hCAFEF00D});
    exp_q.push_back({32'd1600, 32'h12345600});
    exp_q.push_back({32'd1604, 32'h55667700});
    fb = fill_count;
    run_access(1'b1, 32'h100, 1'b1, 32'd1601, 4, 32'hAA998811, n, done);
    check("t2_inst_first", 96'(fill_at[fb]), 96'(n + 4));
    check("t2_fill_1600", 96'(fill_at[fb + 1]), 96'(n + 9));
    check("t2_fill_1604", 96'(fill_at[fb + 2]), 96'(n + 14));
    check("t2_no_ram_wr", 96'(ram_writes), 96'd0);

    // Byte store at 2627 displacing the dirty line 1600 (same index 144).
    exp_q.push_back({32'd3072, 32'h11223344});
`ifdef CACHE_CTRL_WRITEBACK_EN
    ram_exp_q.push_back({32'd800, 16'h1100});
    ram_exp_q.push_back({32'd801, 16'h9988});
`endif
    exp_q.push_back({32'd2624, 32'h0BADBEEF});
    fb = fill_count;
    run_access(1'b1, 32'd3072, 1'b1, 32'd2627, 1, 32'h0000005A, n, done);
    check("t3_inst_fill", 96'(fill_at[fb]), 96'(n + 4));
    check("t3_data_fill", 96'(fill_at[fb + 1]), 96'(n + 9 + WB_EXTRA));
    check("t3_ram_writes", 96'(ram_writes), 96'(EXP_RAM_WR));

    // Reset pulse during RD_HI of an instruction refill, then restart.
    exp_q.push_back({32'h200, 32'h0F1E2D3C});
    @(negedge clk);
    i_act = 1'b1; i_addr = 32'h200;
    n = cyc;
    repeat (2) @(negedge clk);
    check("t4_in_rd_hi", fsm_state, ST_RD_HI);
    fb = fill_count;
    reset_n = 1'b0;
    #1;
    check_outputs_zero("t4_rst");
    @(negedge clk);
    check_outputs_zero("t4_rst_hold");
    reset_n = 1'b1;
    m = cyc;
    wait_done(1'b0, done);
    i_act = 1'b0;
    check("t4_restart_fill", 96'(fill_at[fb]), 96'(m + 4));
    check("t4_fill_count", 96'(fill_count), 96'(fb + 1));

    repeat (3) @(negedge clk);
    check("exp_q_drained", 96'(exp_q.size()), 96'd0);
    check("ram_q_drained", 96'(ram_exp_q.size()), 96'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
